fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of mainmem. It owns the PC and drives mainmem's address and read_write inputs.
- Each fetched word is captured from mainmem's data_out into a small instruction FIFO, which feeds decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution.
- Faults on fetches outside the memory window.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_if.sv | 30 +++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the fetch stage
//
// Purpose: memory-bus command encodings, default window geometry, the fetch
//          FSM state type and the window-membership helper.
// Ports:   none (package).
package fetch_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] DEFAULT_STARTING_ADDR   = 32'h0100_0000;
    localparam logic [31:0] DEFAULT_MEM_DEPTH_BYTES = 32'h0010_0000;
    localparam int          DEFAULT_FIFO_DEPTH      = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // A word address is fetchable when the whole word lies inside
    // [base, base + depth).
    function automatic logic pc_in_window(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
        return (pc >= base) && (pc <= base + depth - 32'd4);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction stream handshake from fetch to decode
//
// Purpose: groups the fetch-to-decode valid/ready stream.
// Signals: inst_valid  head of the instruction queue is valid
//          inst_ready  consumer accepts the head
//          inst        instruction word
//          inst_pc     PC of that instruction word
// Modports: master = fetch (producer), slave = decode (consumer).
interface fetch_if;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of {pc, inst} entries
//
// Purpose: buffers fetched words between the PC/fetch logic and decode.
// Ports:   clock, reset_n      clock, async active-low reset
//          push, push_data     write one entry (accepted when not full, or
//                              when a pop happens on the same edge)
//          pop                 remove the head (ignored when empty)
//          flush               empty the FIFO; overrides push and pop
//          head_data           current head; when empty, the last value that
//                              was shown at the head (zero after reset)
//          full, empty, count  occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign head_data = empty ? last_q : mem[rd_ptr];

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            // Keep showing the flushed head so the outputs hold while empty.
            if (!empty) begin
                last_q <= mem[rd_ptr];
            end
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, memory read, instruction queue
//
// Purpose: owns the PC, reads mainmem combinationally at the PC, queues
//          {pc, word} pairs for decode, handles redirects and faults on
//          out-of-window or misaligned fetch targets.
// Optional: FETCH_BYPASS_EN - when defined, an empty queue in RUN presents
//           the memory word to decode combinationally (zero latency).
// Ports:   clock, reset_n                     clock, async active-low reset
//          mem_address/read_write/data_in     drive mainmem (read-only use)
//          mem_data_out                       mainmem read data for mem_address
//          redirect_valid, redirect_pc        load a new PC, flush the queue
//          inst_if (fetch_if.master)          instruction stream to decode
//          fetch_fault                        sticky fault, cleared by redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
    parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES,
    parameter int          FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    fetch_if.master     inst_if,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;

    logic          pc_ok;
    logic          bypass_hit;
    logic          inst_valid_int;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head;

    assign pc_ok = pc_in_window(pc_q, STARTING_ADDR, MEM_DEPTH_BYTES);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = (fifo_count == '0) && (state_q == RUN) && pc_ok && !redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign inst_valid_int     = (fifo_count != '0) || bypass_hit;
    assign inst_if.inst_valid = inst_valid_int;
    assign inst_if.inst       = bypass_hit ? mem_data_out : fifo_head[31:0];
    assign inst_if.inst_pc    = bypass_hit ? pc_q         : fifo_head[63:32];

    assign mem_address    = pc_q;
    assign mem_read_write = READ;
    assign mem_data_in    = 32'd0;
    assign fetch_fault    = fault_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({pc_q, mem_data_out}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= STARTING_ADDR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            BOOT: begin
                // Address is already on the bus; give memory one cycle.
                state_d = RUN;
            end

            RUN, HALT: begin
                if (redirect_valid) begin
                    // Redirect wins over everything, including a pop.
                    fifo_flush = 1'b1;
                    pc_d       = {redirect_pc[31:2], 2'b00};
                    state_d    = RUN;
                    fault_d    = |redirect_pc[1:0];
                end else begin
                    fifo_pop = inst_valid_int && inst_if.inst_ready && !fifo_empty;
                    if (state_q == RUN) begin
                        if (!pc_ok) begin
                            state_d = HALT;
                            fault_d = 1'b1;
                        end else if (bypass_hit && inst_if.inst_ready) begin
                            // Word consumed straight from memory; nothing to queue.
                            pc_d = pc_q + 32'd4;
                        end else if (!fifo_full || fifo_pop) begin
                            fifo_push = 1'b1;
                            pc_d      = pc_q + 32'd4;
                        end
                    end
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] START   = 32'h0100_0000;
    localparam logic [31:0] DEPTH_B = 32'h0010_0000;
    localparam logic [31:0] LAST    = START + DEPTH_B - 32'd4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fetch_fault;

    fetch_if inst_bus ();

    fetch_unit #(
        .STARTING_ADDR   (START),
        .MEM_DEPTH_BYTES (DEPTH_B),
        .FIFO_DEPTH      (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_if        (inst_bus),
        .fetch_fault    (fetch_fault)
    );

    always #5 clock = ~clock;

    // Memory contents: a fixed word at the boot address, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == START) return 32'h0000_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    assign mem_data_out = mem_word(mem_address);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic exp_fault = 1'b0;
    logic fault_chk_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Decode must see the consecutive words from the (aligned) target up to
    // the end of the window, in order, each exactly once.
    task automatic expect_stream(input logic [31:0] target);
        logic [31:0] a;
        exp_q.delete();
        a = {target[31:2], 2'b00};
        for (int i = 0; i < 4096; i++) begin
            if (a < START || a > LAST) break;
            exp_q.push_back('{a, mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: at the negedge, inputs are stable until the next posedge, so
    // valid && ready here means a transfer on the coming edge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (fault_chk_en) check("fetch_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});
            if (prev_stall && inst_bus.inst_valid) begin
                check("stall_pc_stable", inst_bus.inst_pc, prev_pc);
                check("stall_inst_stable", inst_bus.inst, prev_inst);
            end
            if (inst_bus.inst_valid && inst_bus.inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transfer: actual pc=%h required no transfer", inst_bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc", inst_bus.inst_pc, e.pc);
                    check("xfer_inst", inst_bus.inst, e.word);
                end
            end
            prev_stall = inst_bus.inst_valid && !inst_bus.inst_ready && !redirect_valid;
            prev_pc    = inst_bus.inst_pc;
            prev_inst  = inst_bus.inst;
        end
    end

    initial begin
        logic [31:0] tgt;
        inst_bus.inst_ready = 1'b1;
        expect_stream(START);

        // Reset state
        #12;
        check("rst_valid", {31'd0, inst_bus.inst_valid}, 32'd0);
        check("rst_inst", inst_bus.inst, 32'd0);
        check("rst_inst_pc", inst_bus.inst_pc, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_mem_address", mem_address, START);
        check("rst_read_write", {31'd0, mem_read_write}, 32'd0);
        check("rst_data_in", mem_data_in, 32'd0);

        step();
        reset_n = 1'b1;

        // First fetch latency
        step();
`ifndef FETCH_BYPASS_EN
        check("boot_no_capture", {31'd0, inst_bus.inst_valid}, 32'd0);
        step();
`endif
        check("first_valid", {31'd0, inst_bus.inst_valid}, 32'd1);
        check("first_inst", inst_bus.inst, 32'h0000_0093);
        check("first_pc", inst_bus.inst_pc, START);

        // Back-pressure: queue fills, address stops advancing
        inst_bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_head_pc", inst_bus.inst_pc, START);
        end
        check("stall_mem_address", mem_address, START + 32'd8);
        inst_bus.inst_ready = 1'b1;
        step();
        step();
        check("drain_pc", inst_bus.inst_pc, START + 32'd8);
        step();
        check("stream_pc", inst_bus.inst_pc, START + 32'd12);

        // Redirect with a full queue and ready high
        inst_bus.inst_ready = 1'b0;
        step();
        inst_bus.inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = START + 32'h100;
        step();
        redirect_valid = 1'b0;
        expect_stream(START + 32'h100);
`ifndef FETCH_BYPASS_EN
        check("redir_flush_valid", {31'd0, inst_bus.inst_valid}, 32'd0);
        step();
`endif
        check("redir_valid", {31'd0, inst_bus.inst_valid}, 32'd1);
        check("redir_pc", inst_bus.inst_pc, START + 32'h100);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = START + 32'h6;
        step();
        redirect_valid = 1'b0;
        exp_fault = 1'b1;
        expect_stream(START + 32'h6);
        check("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        check("misalign_pc", mem_address, START + 32'h4);
        repeat (4) step();
        check("misalign_sticky", {31'd0, fetch_fault}, 32'd1);

        // Window end: two words, then HALT with a fault
        redirect_valid = 1'b1;
        redirect_pc = LAST - 32'd4;
        step();
        redirect_valid = 1'b0;
        exp_fault = 1'b0;
        fault_chk_en = 1'b0;
        expect_stream(LAST - 32'd4);
        check("end_fault_clear", {31'd0, fetch_fault}, 32'd0);
        repeat (3) step();
        check("end_fault", {31'd0, fetch_fault}, 32'd1);
        check("end_mem_address", mem_address, START + DEPTH_B);
        repeat (5) step();
        check("halt_mem_frozen", mem_address, START + DEPTH_B);
        check("halt_valid", {31'd0, inst_bus.inst_valid}, 32'd0);
        check("halt_drained", exp_q.size(), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = START;
        step();
        redirect_valid = 1'b0;
        expect_stream(START);
        check("resume_fault", {31'd0, fetch_fault}, 32'd0);
        fault_chk_en = 1'b1;
        repeat (2) step();
        check("resume_valid", {31'd0, inst_bus.inst_valid}, 32'd1);

        // Async reset mid-stream with a full queue
        inst_bus.inst_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, inst_bus.inst_valid}, 32'd0);
        check("async_rst_mem_address", mem_address, START);
        check("async_rst_inst_pc", inst_bus.inst_pc, 32'd0);
        expect_stream(START);
        exp_fault = 1'b0;
        step();
        reset_n = 1'b1;
        inst_bus.inst_ready = 1'b1;
        repeat (4) step();
        check("post_rst_valid", {31'd0, inst_bus.inst_valid}, 32'd1);

        // Randomized traffic with redirects
        for (int c = 0; c < 3000; c++) begin
            inst_bus.inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                tgt = START + ($urandom_range(0, 32'hFFFF) << 2);
                if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                redirect_valid = 1'b1;
                redirect_pc = tgt;
                step();
                redirect_valid = 1'b0;
                exp_fault = (tgt[1:0] != 2'b00);
                expect_stream(tgt);
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
